quantum_gate_sequencer: RTL
===========================

# quantum_gate_sequencer

Single-qubit gate sequencer that sits in front of `quantum_state` and is the only block that drives its `update_en`, `alpha_in` and `beta_in`. It buffers gate opcodes from the host in a small FIFO and pops them one at a time. For each opcode it computes the new Q16.16 signed amplitudes from the current `alpha_out`/`beta_out`, then pulses `update_en` for exactly one cycle. It waits for the state register to settle before fetching the next gate.

## Interface
- `DEPTH`, default 4: opcode FIFO depth, a power of 2 and at least 2.
- `INV_SQRT2`, default 32'h0000_B505: 1/√2 in Q16.16.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: host offers an opcode.
- `cmd_op`  in  3: opcode. 0 = NOP, 1 = X, 2 = Z, 3 = H, 4 = INIT. 5–7 are illegal.
- `cmd_ready`  out  1: FIFO can accept; equals `!full`.
- `hold`  in  1: when high, no new opcode is popped.
- `alpha_cur`, `beta_cur`  in  32 each: current state, from `quantum_state` outputs.
- `update_en`  out  1: one-cycle write strobe to `quantum_state`.
- `alpha_new`, `beta_new`  out  32 each: registered next-state amplitudes.
- `busy`  out  1: FSM not in IDLE, or FIFO not empty.
- `done`  out  1: one-cycle pulse per retired opcode.
- `gate_count`  out  16: number of retired opcodes; wraps 0xFFFF→0.
- `err`  out  1: sticky; set by an illegal opcode.
- `fifo_count`  out  $clog2(DEPTH)+1: number of queued opcodes.

## Operation
- **Reset values.** At a reset edge:
  - FSM goes to IDLE and the FIFO is emptied.
  - `update_en`=0, `done`=0, `err`=0, `gate_count`=0, `fifo_count`=0.
  - `alpha_new`=32'h0001_0000, `beta_new`=0.
  - `cmd_ready`=1.
  - Reset mid-gate abandons the gate; no `update_en` is issued after the reset edge.
- **FIFO push.** A push occurs when `cmd_valid && cmd_ready`.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pushes while full are blocked by `cmd_ready`=0.
  - Read and write pointers wrap modulo DEPTH.
- **FSM states:**
  - IDLE: if FIFO not empty and `!hold`, pop the head into `op_r`, latch `alpha_cur`/`beta_cur` into `a_r`/`b_r`, go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute the result into `alpha_new`/`beta_new`, go to WRITE.
  - WRITE: `update_en`=1 if `op_r` is X, Z, H or INIT; otherwise 0. Go to SETTLE.
  - SETTLE: `done`=1, `gate_count`+1, go to IDLE.
- **Arithmetic.** All values are two's-complement Q16.16.
  - X: `alpha_new`=`b_r`, `beta_new`=`a_r`.
  - Z: `alpha_new`=`a_r`, `beta_new`=0−`b_r` (32-bit wrap).
  - H:
    - s = `a_r`+`b_r` and d = `a_r`−`b_r`, each sign-extended to 33 bits.
    - Multiply each by `INV_SQRT2` as a 66-bit signed product.
    - Arithmetic shift right by 16 (floor), then take the low 32 bits.
    - No saturation.
  - INIT: `alpha_new`=32'h0001_0000, `beta_new`=0.
  - NOP: `alpha_new`/`beta_new` keep their previous values.
  - Illegal opcode: treated as NOP and sets `err`. `err` clears only on reset.
- **`hold`.** Sampled only in IDLE. A gate already in EXEC, WRITE or SETTLE always completes.

## Timing
- Pop edge to `update_en`: 2 cycles (EXEC, then WRITE).
- Issue period: 4 cycles per opcode, including when the FIFO stays non-empty.
- `quantum_state` registers the new value at the end of the WRITE cycle; its outputs are valid during SETTLE. The next IDLE therefore latches the updated state, so there is no read-after-write hazard.
- `done` is high in SETTLE, exactly one cycle after the WRITE cycle.
- `gate_count` is visible incremented the cycle after SETTLE.
- `cmd_ready` and `fifo_count` reflect registered FIFO state, with no combinational path from `cmd_valid`.
- Push-to-execute latency from an empty FIFO in IDLE: the push edge, then the pop on the next edge.

## Test plan
- **Reset state:** assert `reset` for 2 cycles → `alpha_new`=0x00010000, `beta_new`=0, `update_en`=0, `cmd_ready`=1, `gate_count`=0, `err`=0.
- **X gate:** X on state (0x00010000, 0) → `update_en` pulses once with `alpha_new`=0, `beta_new`=0x00010000. `done` pulses the next cycle and `gate_count`=1.
- **H and Z sequence:** H, H, H, Z from |0⟩:
  - after the first H → (0x0000B505, 0x0000B505);
  - after the second H → (0x00010000, 0x00000000);
  - after the final Z → (0x0000B505, 0xFFFF4AFB);
  - `update_en` pulses spaced exactly 4 cycles apart.
- **FIFO full with hold:** with `hold`=1, push 5 opcodes back-to-back → `cmd_ready` drops after the 4th, `fifo_count`=4, the 5th is not accepted. Release `hold` → 4 gates retire and `cmd_ready` returns high after the first pop.
- **Illegal opcode:** push 7 → no `update_en`, `done` pulses, `gate_count` increments, `err`=1 and stays high through subsequent legal gates.
- **Reset mid-gate:** assert `reset` in the EXEC cycle of an X → no `update_en` follows, the FIFO is emptied, all outputs return to their reset values.

Source files
------------

// File: rtl/quantum_gate_sequencer.sv
// rtl/quantum_gate_sequencer.sv - single-qubit gate sequencer driving quantum_state updates
//
// Purpose:
//   Queues 3-bit gate opcodes from the host in a small FIFO. It pops them one at a time.
//   For each opcode it computes the next Q16.16 amplitudes from the current state,
//   then issues a one-cycle update strobe to quantum_state.
//   Each opcode takes 4 cycles: IDLE (pop), EXEC, WRITE, SETTLE.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_op        host opcode offer (0 NOP, 1 X, 2 Z, 3 H, 4 INIT, 5-7 illegal)
//   cmd_ready               FIFO not full
//   hold                    blocks popping while the FSM is in IDLE
//   alpha_cur, beta_cur     current state from quantum_state
//   update_en               one-cycle write strobe (WRITE cycle)
//   alpha_new, beta_new     registered next-state amplitudes
//   busy                    FSM active or FIFO not empty
//   done                    one-cycle pulse per retired opcode (SETTLE cycle)
//   gate_count              retired opcode counter, wraps
//   err                     sticky illegal-opcode flag
//   fifo_count              queued opcode count

module quantum_gate_sequencer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] INV_SQRT2 = 32'h0000_B505
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_op,
    output logic                     cmd_ready,
    input  logic                     hold,
    input  logic [31:0]              alpha_cur,
    input  logic [31:0]              beta_cur,
    output logic                     update_en,
    output logic [31:0]              alpha_new,
    output logic [31:0]              beta_new,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              gate_count,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_X    = 3'd1;
    localparam logic [2:0] OP_Z    = 3'd2;
    localparam logic [2:0] OP_H    = 3'd3;
    localparam logic [2:0] OP_INIT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_WRITE  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Opcode FIFO
    // ------------------------------------------------------------------
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state_q;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    // Popping is only possible in IDLE; hold is ignored once a gate is in flight.
    assign pop   = (state_q == S_IDLE) && !empty && !hold;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Hadamard datapath: (a +/- b) * 1/sqrt2, floor shift by 16, low 32 bits
    // ------------------------------------------------------------------
    logic [2:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic signed [32:0] h_sum;
    logic signed [32:0] h_dif;
    logic signed [32:0] h_k;
    logic signed [65:0] h_psum;
    logic signed [65:0] h_pdif;
    logic               unused_hbits;

    assign h_sum  = $signed({a_q[31], a_q}) + $signed({b_q[31], b_q});
    assign h_dif  = $signed({a_q[31], a_q}) - $signed({b_q[31], b_q});
    assign h_k    = $signed({INV_SQRT2[31], INV_SQRT2});
    assign h_psum = 66'(h_sum) * 66'(h_k);
    assign h_pdif = 66'(h_dif) * 66'(h_k);
    // Bits [47:16] of the product are the floor-shifted result truncated to 32 bits.
    assign unused_hbits = ^{h_psum[65:48], h_psum[15:0], h_pdif[65:48], h_pdif[15:0]};

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    logic [31:0] alpha_q;
    logic [31:0] beta_q;
    logic        update_q;
    logic        done_q;
    logic [15:0] gcnt_q;
    logic        err_q;
    logic        op_writes;

    assign op_writes = (op_q == OP_X) || (op_q == OP_Z) || (op_q == OP_H) || (op_q == OP_INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            alpha_q  <= 32'h0001_0000;
            beta_q   <= '0;
            update_q <= 1'b0;
            done_q   <= 1'b0;
            gcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_q    <= mem_q[rd_ptr_q];
                        a_q     <= alpha_cur;
                        b_q     <= beta_cur;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_X: begin
                            alpha_q <= b_q;
                            beta_q  <= a_q;
                        end
                        OP_Z: begin
                            alpha_q <= a_q;
                            beta_q  <= 32'd0 - b_q;
                        end
                        OP_H: begin
                            alpha_q <= h_psum[47:16];
                            beta_q  <= h_pdif[47:16];
                        end
                        OP_INIT: begin
                            alpha_q <= 32'h0001_0000;
                            beta_q  <= '0;
                        end
                        OP_NOP: begin
                        end
                        default: begin
                            err_q <= 1'b1;
                        end
                    endcase
                    // Strobe is high during WRITE, the cycle after this edge.
                    update_q <= op_writes;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    gcnt_q  <= gcnt_q + 16'd1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = !full;
    assign fifo_count = count_q;
    assign update_en  = update_q;
    assign alpha_new  = alpha_q;
    assign beta_new   = beta_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign done       = done_q;
    assign gate_count = gcnt_q;
    assign err        = err_q;

endmodule
